// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector searching from ptr+1
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  logic [SW-1:0] sum;
  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      sum = {1'b0, ptr} + SW'(off);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin packet arbiter for the FIFO write port
module async_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          busy,
  output logic [7:0]                    burst_cnt
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, pick_idx;
  logic [7:0]    cnt_nxt;
  logic          pick_found, owner_valid, owner_last, accept, end_grant;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req   (src_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy       = (state == BURST);
  assign accept     = owner_valid && !fifo_full;
  assign fifo_wr_en = accept;
  assign end_grant  = accept && (owner_last || (burst_cnt == LAST_BEAT));

  // Route the owner's handshake and data; ready drops the same cycle the FIFO fills.
  always_comb begin
    owner_valid  = 1'b0;
    owner_last   = 1'b0;
    fifo_wr_data = '0;
    src_ready    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (busy && (grant_id == IW'(i))) begin
        owner_valid  = src_valid[i];
        owner_last   = src_last[i];
        fifo_wr_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        src_ready[i] = !fifo_full;
      end
    end
  end

  // Next-state: one arbitration cycle in IDLE, then hold the grant until last beat or burst cap.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    cnt_nxt    = burst_cnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (end_grant) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_id;
          cnt_nxt    = '0;
        end else if (accept) begin
          cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and grant registers; reset aborts any grant and makes source 0 first in line.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= IW'(NUM_SRC - 1);
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  a_ready_onehot0 : assert property (@(posedge wr_clk) disable iff (wr_rst) $onehot0(src_ready));
  a_no_wr_on_full : assert property (@(posedge wr_clk) disable iff (wr_rst) !(fifo_wr_en && fifo_full));
  a_grant_range   : assert property (@(posedge wr_clk) disable iff (wr_rst) int'(grant_id) < NUM_SRC);

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - directed scoreboard bench for the FIFO write arbiter
module tb_async_fifo_wr_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic            wr_clk = 1'b0;
  logic            wr_rst = 1'b1;
  logic [NS-1:0]   src_valid, src_last, src_ready;
  logic [NS*DW-1:0] src_data;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [7:0]      burst_cnt;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] mem [NS][32];
  int         rd [NS];
  int         wr [NS];
  logic [NS-1:0] hold  = '0;
  logic [NS-1:0] fired = '0;
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] max_cnt = '0;

  async_fifo_wr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .burst_cnt    (burst_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  for (genvar g = 0; g < NS; g++) begin : g_src
    assign src_valid[g]        = (rd[g] != wr[g]) && !hold[g];
    assign src_last[g]         = mem[g][rd[g] % 32][8];
    assign src_data[g*DW +: DW] = mem[g][rd[g] % 32][7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic load(input int s, input logic [7:0] d, input logic last);
    mem[s][wr[s] % 32] = {last, d};
    wr[s]++;
  endtask

  task automatic expect_wr(input int s, input logic [7:0] d);
    exp_q.push_back('{id: 2'(s), data: d});
  endtask

  task automatic reset_dut();
    @(posedge wr_clk); #2;
    wr_rst    = 1'b1;
    fifo_full = 1'b0;
    hold      = '0;
    for (int i = 0; i < NS; i++) rd[i] = wr[i];
    exp_q.delete();
    @(posedge wr_clk); #2;
    wr_rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (k < budget && !(exp_q.size() == 0 && !busy)) begin
      @(negedge wr_clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every write presented to the FIFO must match the next expected beat.
  always @(negedge wr_clk) begin
    exp_t e;
    if (!wr_rst) begin
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", {31'b0, fifo_wr_en}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_id", {30'b0, grant_id}, {30'b0, e.id});
          chk("wr_data", {24'b0, fifo_wr_data}, {24'b0, e.data});
        end
      end
      fired = src_valid & src_ready;
      if (burst_cnt > max_cnt) max_cnt = burst_cnt;
    end
  end

  // Source model: advance a source's beat pointer after each accepted handshake.
  always @(posedge wr_clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (fired[i] && rd[i] != wr[i]) rd[i]++;
    end
    fired = '0;
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      rd[i] = 0;
      wr[i] = 0;
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    end

    // reset state
    @(negedge wr_clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_grant", {30'b0, grant_id}, 0);
    chk("rst_cnt", {24'b0, burst_cnt}, 0);
    chk("rst_ready", {28'b0, src_ready}, 0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 0);
    chk("rst_wr_data", {24'b0, fifo_wr_data}, 0);
    @(posedge wr_clk); #2;
    wr_rst = 1'b0;

    // test 1: single source, 3-beat packet
    @(posedge wr_clk); #2;
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    expect_wr(2, 8'hA1); expect_wr(2, 8'hA2); expect_wr(2, 8'hA3);
    @(negedge wr_clk);
    chk("t1_arb_busy", {31'b0, busy}, 0);
    chk("t1_arb_ready", {28'b0, src_ready}, 0);
    @(negedge wr_clk);
    chk("t1_grant", {30'b0, grant_id}, 2);
    chk("t1_wr1", {31'b0, fifo_wr_en}, 1);
    @(negedge wr_clk);
    chk("t1_wr2", {31'b0, fifo_wr_en}, 1);
    @(negedge wr_clk);
    chk("t1_wr3", {31'b0, fifo_wr_en}, 1);
    @(negedge wr_clk);
    chk("t1_done_busy", {31'b0, busy}, 0);
    chk("t1_done_wr", {31'b0, fifo_wr_en}, 0);
    wait_idle(20, "t1_drain");

    // test 2: all sources, one-beat packets, rotation 0,1,2,3,0
    reset_dut();
    load(0, 8'h20, 1'b1); load(1, 8'h21, 1'b1); load(2, 8'h22, 1'b1); load(3, 8'h23, 1'b1);
    load(0, 8'h24, 1'b1);
    expect_wr(0, 8'h20); expect_wr(1, 8'h21); expect_wr(2, 8'h22); expect_wr(3, 8'h23);
    expect_wr(0, 8'h24);
    for (int k = 0; k < 10; k++) begin
      @(negedge wr_clk);
      chk($sformatf("t2_busy_%0d", k), {31'b0, busy}, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) chk($sformatf("t2_grant_%0d", k), {30'b0, grant_id}, ((k - 1) / 2) % NS);
    end
    wait_idle(20, "t2_drain");

    // test 3: 20-beat packet cut at MAX_BURST, interleaved with source 3
    reset_dut();
    max_cnt = '0;
    for (int n = 0; n < 20; n++) load(1, 8'(8'h10 + n), (n == 19) ? 1'b1 : 1'b0);
    load(3, 8'h30, 1'b0); load(3, 8'h31, 1'b1);
    for (int n = 0; n < 8; n++) expect_wr(1, 8'(8'h10 + n));
    expect_wr(3, 8'h30); expect_wr(3, 8'h31);
    for (int n = 8; n < 20; n++) expect_wr(1, 8'(8'h10 + n));
    wait_idle(200, "t3_drain");
    chk("t3_cnt_peak", {24'b0, max_cnt}, MB - 1);

    // test 4: fifo_full for 5 cycles after beat 3 of 6
    reset_dut();
    for (int n = 0; n < 6; n++) begin
      load(0, 8'(8'h40 + n), (n == 5) ? 1'b1 : 1'b0);
      expect_wr(0, 8'(8'h40 + n));
    end
    @(negedge wr_clk);
    @(negedge wr_clk);
    chk("t4_cnt_b1", {24'b0, burst_cnt}, 0);
    @(negedge wr_clk);
    @(negedge wr_clk);
    chk("t4_cnt_b3", {24'b0, burst_cnt}, 2);
    @(posedge wr_clk); #2;
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wr_clk);
      chk($sformatf("t4_full_ready_%0d", k), {28'b0, src_ready}, 0);
      chk($sformatf("t4_full_wr_%0d", k), {31'b0, fifo_wr_en}, 0);
      chk($sformatf("t4_full_cnt_%0d", k), {24'b0, burst_cnt}, 3);
    end
    @(posedge wr_clk); #2;
    fifo_full = 1'b0;
    @(negedge wr_clk);
    chk("t4_resume_ready", {28'b0, src_ready}, 4'b0001);
    chk("t4_resume_wr", {31'b0, fifo_wr_en}, 1);
    wait_idle(40, "t4_drain");

    // test 5: owner pauses mid-packet while others wait
    reset_dut();
    for (int n = 0; n < 4; n++) begin
      load(0, 8'(8'h50 + n), (n == 3) ? 1'b1 : 1'b0);
      expect_wr(0, 8'(8'h50 + n));
    end
    load(1, 8'h61, 1'b1); load(3, 8'h63, 1'b1);
    expect_wr(1, 8'h61); expect_wr(3, 8'h63);
    @(negedge wr_clk);
    @(negedge wr_clk);
    @(negedge wr_clk);
    @(posedge wr_clk); #2;
    hold[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge wr_clk);
      chk($sformatf("t5_hold_busy_%0d", k), {31'b0, busy}, 1);
      chk($sformatf("t5_hold_grant_%0d", k), {30'b0, grant_id}, 0);
      chk($sformatf("t5_hold_wr_%0d", k), {31'b0, fifo_wr_en}, 0);
    end
    @(posedge wr_clk); #2;
    hold[0] = 1'b0;
    wait_idle(40, "t5_drain");

    // test 6: asynchronous reset mid-burst
    reset_dut();
    load(0, 8'h80, 1'b1);
    expect_wr(0, 8'h80);
    for (int n = 0; n < 8; n++) begin
      load(1, 8'(8'h70 + n), (n == 7) ? 1'b1 : 1'b0);
      expect_wr(1, 8'(8'h70 + n));
    end
    for (int k = 0; k < 50 && !(busy && grant_id == 2'd1 && burst_cnt == 8'd2); k++) @(negedge wr_clk);
    chk("t6_mid_burst", {22'b0, busy, grant_id, burst_cnt}, {22'b0, 1'b1, 2'd1, 8'd2});
    #2;
    wr_rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'b0, busy}, 0);
    chk("t6_rst_ready", {28'b0, src_ready}, 0);
    chk("t6_rst_wr", {31'b0, fifo_wr_en}, 0);
    @(posedge wr_clk); #2;
    for (int i = 0; i < NS; i++) rd[i] = wr[i];
    exp_q.delete();
    @(posedge wr_clk); #2;
    wr_rst = 1'b0;
    load(0, 8'hA0, 1'b1); load(1, 8'hB1, 1'b1);
    expect_wr(0, 8'hA0); expect_wr(1, 8'hB1);
    @(negedge wr_clk);
    chk("t6_arb_busy", {31'b0, busy}, 0);
    @(negedge wr_clk);
    chk("t6_first_grant", {30'b0, grant_id}, 0);
    wait_idle(40, "t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
Shares the single write port of the team's dual-clock FIFO among NUM_SRC requesters in the wr_clk domain. Each requester uses a valid/ready handshake with a last-beat marker. The block grants one requester at a time, round-robin, and holds the grant for a whole packet or up to MAX_BURST beats, whichever comes first. It drives the FIFO write enable and data directly and stalls on FIFO full, so no word is ever presented to a full FIFO.

Parameters:
NUM_SRC, 4, number of requesters (2..16)
DATA_WIDTH, 8, FIFO word width
MAX_BURST, 8, maximum beats per grant before forced re-arbitration (1..255)

Ports:
wr_clk  in  1  write-domain clock
wr_rst  in  1  reset
src_valid  in  NUM_SRC  per-source word valid
src_last  in  NUM_SRC  per-source last beat of packet, qualified by src_valid
src_data  in  NUM_SRC*DATA_WIDTH  packed data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
src_ready  out  NUM_SRC  per-source accept
fifo_full  in  1  full flag from the FIFO write side
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  DATA_WIDTH  FIFO write data
grant_id  out  $clog2(NUM_SRC)  index of the current owner; valid while busy
busy  out  1  a grant is active
burst_cnt  out  8  beats accepted in the current grant

Behaviour:
- Reset: wr_rst is asynchronous, active-high; clock is wr_clk. On reset: state=IDLE, busy=0, grant_id=0, burst_cnt=0, rr_ptr=NUM_SRC-1 (so source 0 wins first). All outputs are 0: src_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- Beat acceptance: a beat is accepted in a cycle when busy, src_valid[grant_id], and !fifo_full.
- src_ready[i] = busy && (grant_id==i) && !fifo_full. This is combinational, so there is zero latency from fifo_full to stall.
- fifo_wr_en = src_valid[grant_id] && src_ready[grant_id].
- fifo_wr_data = src_data slice of grant_id when busy, else 0.
- FSM states: IDLE and BURST.
- IDLE:
  - No source is ready.
  - If any src_valid is set, the next edge does the following: grant_id <= first i with src_valid[i], searching from rr_ptr+1 modulo NUM_SRC; busy <= 1; burst_cnt <= 0; state <= BURST.
  - Arbitration therefore costs exactly one cycle. The first beat can be accepted in the cycle after the request is seen.
- BURST:
  - Each accepted beat increments burst_cnt.
  - End of grant: an accepted beat with src_last[grant_id]=1, or an accepted beat with burst_cnt==MAX_BURST-1. On the next edge: state <= IDLE, busy <= 0, rr_ptr <= grant_id, burst_cnt <= 0.
  - If the owner deasserts valid mid-packet, the grant is held with no timeout. Packets are never interleaved.
- FIFO full: the grant, burst_cnt and state freeze. No beat is lost or duplicated. src_valid held high sees ready return the cycle after full clears.
- Simultaneous requests: resolved purely by the round-robin pointer. A source that just finished has lowest priority in the next arbitration.
- MAX_BURST cut: the packet continues in a later grant. Ownership is fairly rotated and the packet is not dropped.
- Reset mid-burst: the grant is aborted immediately. The FIFO may hold a partial packet, and recovery is the system's responsibility.
- Widths: burst_cnt is 8 bits and never exceeds MAX_BURST-1. rr_ptr and grant_id are $clog2(NUM_SRC) bits, with explicit wrap for non-power-of-2 NUM_SRC.
- Assertions: one-hot-or-zero src_ready; fifo_wr_en never set with fifo_full; grant_id < NUM_SRC.

Decomposition:
- Shared package fifo_arb_pkg: state enum (IDLE, BURST) and the default localparams for NUM_SRC, DATA_WIDTH and MAX_BURST.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and rr_ptr; outputs are found and index. It is reusable for a future read-side scheduler.

Test Plan:
1. After reset, only source 2 is valid and sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3). Required: grant_id=2 one cycle later, fifo_wr_en high for 3 consecutive cycles with those data, then busy=0.
2. All 4 sources are valid with 1-beat packets. Required: grant order 0,1,2,3,0 with exactly one idle arbitration cycle between grants.
3. Source 1 sends a 20-beat packet with MAX_BURST=8 while source 3 is also valid. Required: the write stream is 8 beats of source 1, then source 3's packet, then 8 beats of source 1, then the remaining 4 beats of source 1; burst_cnt peaks at 7.
4. fifo_full is asserted for 5 cycles mid-burst on beat 3 of 6. Required: src_ready=0 and fifo_wr_en=0 for those 5 cycles, burst_cnt holds at 3, beats 4-6 are written afterward with no loss or duplication.
5. The owner drops src_valid for 4 cycles mid-packet while other sources are valid. Required: the grant is held and no other source is written until the owner's last beat is accepted.
6. wr_rst is pulsed asynchronously mid-burst. Required: busy, src_ready and fifo_wr_en go to 0 immediately; the next grant goes to the lowest valid index, starting from source 0.
